// File: rtl/cal_angle_cordic_if.sv
// Sample bus of the CORDIC angle engine: complex input with channel/mode tags in, angle out.
// Plain valid strobes in both directions; the engine never stalls its source.
interface cal_angle_cordic_if #(
    parameter int IN_W  = 8,
    parameter int ANG_W = 16,
    parameter int CH_W  = 2
);
    logic                    val_i;
    logic signed [IN_W-1:0]  real_i;
    logic signed [IN_W-1:0]  imag_i;
    logic [CH_W-1:0]         ch_i;
    logic                    mode_i;
    logic                    val_o;
    logic signed [ANG_W-1:0] angle_o;
    logic [CH_W-1:0]         ch_o;

    modport master (
        output val_i, real_i, imag_i, ch_i, mode_i,
        input  val_o, angle_o, ch_o
    );

    modport slave (
        input  val_i, real_i, imag_i, ch_i, mode_i,
        output val_o, angle_o, ch_o
    );
endinterface

// File: rtl/cal_angle_cordic.sv
// Pipelined CORDIC vectoring atan2(imag, real) with per-channel differential (FM) phase.
// Latency ITER+2 clocks at 1 sample/clk; no backpressure, every accepted sample emerges.
module cal_angle_cordic #(
    parameter int IN_W     = 8,
    parameter int ANG_W    = 16,
    parameter int ANG_FRAC = 12,
    parameter int ITER     = 12,
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    cal_angle_cordic_if.slave bus
);
    // x/y carry ANG_FRAC guard fraction bits so late-stage truncation stays below the angle LSB
    localparam int XG = ANG_FRAC;
    localparam int XW = IN_W + 2 + XG;
    localparam int ZW = ANG_W + 2;
    localparam int SH = 28 - ANG_FRAC;

    localparam longint PI30 = 64'sd3373259426;
    localparam longint PI_Z = (PI30 + (longint'(1) << (SH - 1))) >>> SH;
    localparam longint PI_A = (PI30 + (longint'(1) << (SH + 1))) >>> (SH + 2);

    localparam logic signed [ZW-1:0] PI_ZS    = ZW'(PI_Z);
    localparam logic signed [ZW-1:0] PI_AZ    = ZW'(PI_A);
    localparam logic signed [ZW-1:0] TWO_PI_Z = ZW'(2 * PI_A);
    localparam logic signed [ZW-1:0] Z_HALF   = ZW'(2);

    // atan(2^-i) scaled by 2^30, rescaled to the z format below
    function automatic longint atan30(input int i);
        case (i)
            0:       return 64'sd843314857;
            1:       return 64'sd497837830;
            2:       return 64'sd263043837;
            3:       return 64'sd133525159;
            4:       return 64'sd67021687;
            5:       return 64'sd33543516;
            6:       return 64'sd16775851;
            7:       return 64'sd8388437;
            8:       return 64'sd4194283;
            9:       return 64'sd2097149;
            default: return longint'(1) << (30 - i);
        endcase
    endfunction

    function automatic logic signed [ZW-1:0] atan_z(input int i);
        longint v;
        v = (atan30(i) + (longint'(1) << (SH - 1))) >>> SH;
        return ZW'(v);
    endfunction

    logic                   r_iv, r_imd;
    logic [CH_W-1:0]        r_ich;
    logic signed [IN_W-1:0] r_ire, r_iim;
    logic [CH_W-1:0]        w_ch;

    logic signed [XW-1:0]   w_ex, w_ey, w_fx, w_fy;
    logic signed [ZW-1:0]   w_fz;

    logic signed [XW-1:0]   r_x  [0:ITER];
    logic signed [XW-1:0]   r_y  [0:ITER];
    logic signed [ZW-1:0]   r_z  [0:ITER];
    logic                   r_v  [0:ITER];
    logic                   r_md [0:ITER];
    logic                   r_zf [0:ITER];
    logic [CH_W-1:0]        r_ch [0:ITER];

    logic signed [ZW-1:0]    w_zr, w_sat, w_d;
    logic signed [ANG_W-1:0] w_abs, w_prev, w_out;

    logic signed [ANG_W-1:0] r_prev [NUM_CH];
    logic [NUM_CH-1:0]       r_have;
    logic                    r_vo;
    logic signed [ANG_W-1:0] r_ang;
    logic [CH_W-1:0]         r_cho;

    // out-of-range tags share channel 0's state and are reported as channel 0
    assign w_ch = (32'(bus.ch_i) < 32'(NUM_CH)) ? bus.ch_i : '0;

    always_comb begin
        w_ex = {{2{r_ire[IN_W-1]}}, r_ire, {XG{1'b0}}};
        w_ey = {{2{r_iim[IN_W-1]}}, r_iim, {XG{1'b0}}};
        w_fx = w_ex;
        w_fy = w_ey;
        w_fz = '0;
        if (w_ex < 0) begin
            w_fx = -w_ex;
            w_fy = -w_ey;
            w_fz = (w_ey >= 0) ? PI_ZS : -PI_ZS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iv  <= 1'b0;
            r_imd <= 1'b0;
            r_ich <= '0;
            r_ire <= '0;
            r_iim <= '0;
            for (int k = 0; k <= ITER; k++) begin
                r_x[k]  <= '0;
                r_y[k]  <= '0;
                r_z[k]  <= '0;
                r_v[k]  <= 1'b0;
                r_md[k] <= 1'b0;
                r_zf[k] <= 1'b0;
                r_ch[k] <= '0;
            end
        end else begin
            r_iv  <= bus.val_i;
            r_imd <= bus.mode_i;
            r_ich <= w_ch;
            r_ire <= bus.real_i;
            r_iim <= bus.imag_i;

            r_x[0]  <= w_fx;
            r_y[0]  <= w_fy;
            r_z[0]  <= w_fz;
            r_v[0]  <= r_iv;
            r_md[0] <= r_imd;
            r_ch[0] <= r_ich;
            r_zf[0] <= (r_ire == '0) && (r_iim == '0);

            for (int k = 1; k <= ITER; k++) begin
                if (r_y[k-1] >= 0) begin
                    r_x[k] <= r_x[k-1] + (r_y[k-1] >>> (k - 1));
                    r_y[k] <= r_y[k-1] - (r_x[k-1] >>> (k - 1));
                    r_z[k] <= r_z[k-1] + atan_z(k - 1);
                end else begin
                    r_x[k] <= r_x[k-1] - (r_y[k-1] >>> (k - 1));
                    r_y[k] <= r_y[k-1] + (r_x[k-1] >>> (k - 1));
                    r_z[k] <= r_z[k-1] - atan_z(k - 1);
                end
                r_v[k]  <= r_v[k-1];
                r_md[k] <= r_md[k-1];
                r_zf[k] <= r_zf[k-1];
                r_ch[k] <= r_ch[k-1];
            end
        end
    end

    always_comb begin
        w_zr = (r_z[ITER] + Z_HALF) >>> 2;
        if (r_zf[ITER])
            w_sat = '0;
        else if (w_zr > PI_AZ)
            w_sat = PI_AZ;
        else if (w_zr < -PI_AZ)
            w_sat = -PI_AZ;
        else
            w_sat = w_zr;
        w_abs  = ANG_W'(w_sat);
        w_prev = r_prev[r_ch[ITER]];

        // wrap the phase step into (-pi, pi]
        w_d = ZW'(w_abs) - ZW'(w_prev);
        if (w_d > PI_AZ)
            w_d = w_d - TWO_PI_Z;
        else if (w_d <= -PI_AZ)
            w_d = w_d + TWO_PI_Z;

        if (!r_md[ITER])
            w_out = w_abs;
        else if (r_have[r_ch[ITER]])
            w_out = ANG_W'(w_d);
        else
            w_out = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vo   <= 1'b0;
            r_ang  <= '0;
            r_cho  <= '0;
            r_have <= '0;
            for (int c = 0; c < NUM_CH; c++)
                r_prev[c] <= '0;
        end else begin
            r_vo <= r_v[ITER];
            if (r_v[ITER]) begin
                r_ang                <= w_out;
                r_cho                <= r_ch[ITER];
                r_prev[r_ch[ITER]]   <= w_abs;
                r_have[r_ch[ITER]]   <= 1'b1;
            end else begin
                r_ang <= '0;
                r_cho <= '0;
            end
        end
    end

    assign bus.val_o   = r_vo;
    assign bus.angle_o = r_ang;
    assign bus.ch_o    = r_cho;
endmodule

// File: tb/tb_cal_angle_cordic.sv
// Directed and random bench for cal_angle_cordic against a floating-point atan2 model.
module tb_cal_angle_cordic;
    localparam int IN_W = 8, ANG_W = 16, ANG_FRAC = 12, ITER = 12, NUM_CH = 4, CH_W = 2;
    localparam int LAT = ITER + 2;
    localparam int PI_A = 12868;
    localparam int TWO_PI = 25736;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cal_angle_cordic_if #(.IN_W(IN_W), .ANG_W(ANG_W), .CH_W(CH_W)) bus ();

    cal_angle_cordic #(
        .IN_W(IN_W), .ANG_W(ANG_W), .ANG_FRAC(ANG_FRAC),
        .ITER(ITER), .NUM_CH(NUM_CH), .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit v;
        int re;
        int im;
        int ch;
        bit md;
        bit fen;
        int fval;
        int tol;
    } rec_t;

    rec_t hist[$];
    int   m_prev [NUM_CH];
    bit   m_have [NUM_CH];
    int   tests = 0;
    int   fails = 0;

    function automatic int ideal(int re, int im);
        if (re == 0 && im == 0) return 0;
        return int'($atan2(real'(im), real'(re)) * 4096.0);
    endfunction

    function automatic int wrap(int d);
        int r;
        r = d;
        while (r > PI_A) r = r - TWO_PI;
        while (r <= -PI_A) r = r + TWO_PI;
        return r;
    endfunction

    task automatic chk(string tag, int obs, int expv, int tol, bit modular);
        int err;
        bit ok;
        err = modular ? wrap(obs - expv) : (obs - expv);
        ok = (err <= tol) && (err >= -tol);
        tests++;
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, expv, tol);
        end
    endtask

    // one clock: drive, clock, then check whatever the sample LAT steps back should produce
    task automatic step(bit rb, bit v, int re, int im, int ch, bit md, bit fen, int fval, int tl);
        rec_t r, e;
        bit   ev;
        int   obs, abs_e, exp_a, tol;
        rst         = rb;
        bus.val_i   = v;
        bus.real_i  = IN_W'(re);
        bus.imag_i  = IN_W'(im);
        bus.ch_i    = CH_W'(ch);
        bus.mode_i  = md;
        r = '{v, re, im, ch, md, fen, fval, tl};
        @(posedge clk);
        #1;
        if (rb) begin
            hist.delete();
            for (int c = 0; c < NUM_CH; c++) begin
                m_have[c] = 1'b0;
                m_prev[c] = 0;
            end
        end else begin
            hist.push_back(r);
        end
        ev = 1'b0;
        e  = r;
        if (hist.size() > LAT) begin
            e  = hist.pop_front();
            ev = e.v;
        end
        obs = int'(bus.angle_o);
        chk("val_o", int'(bus.val_o), int'(ev), 0, 1'b0);
        if (ev) begin
            abs_e = ideal(e.re, e.im);
            if (!e.md) begin
                exp_a = abs_e; tol = 4;
            end else if (!m_have[e.ch]) begin
                exp_a = 0; tol = 0;
            end else begin
                exp_a = wrap(abs_e - m_prev[e.ch]); tol = 8;
            end
            m_prev[e.ch] = abs_e;
            m_have[e.ch] = 1'b1;
            if (e.fen) chk("angle_directed", obs, e.fval, e.tol, 1'b0);
            else       chk("angle_model", obs, exp_a, tol, 1'b1);
            chk("ch_o", int'(bus.ch_o), e.ch, 0, 1'b0);
        end else begin
            chk("angle_idle", obs, 0, 0, 1'b0);
            chk("ch_idle", int'(bus.ch_o), 0, 0, 1'b0);
        end
    endtask

    task automatic drv(bit v, int re, int im, int ch, bit md);
        step(1'b0, v, re, im, ch, md, 1'b0, 0, 0);
    endtask

    task automatic fix(int re, int im, int ch, bit md, int val, int tl);
        step(1'b0, 1'b1, re, im, ch, md, 1'b1, val, tl);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drv(1'b0, 0, 0, 0, 1'b0);
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        bus.val_i  = 1'b0;
        bus.real_i = '0;
        bus.imag_i = '0;
        bus.ch_i   = '0;
        bus.mode_i = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);

        fix(100, 0, 0, 1'b0, 0, 4);
        fix(0, 100, 0, 1'b0, 6434, 4);
        fix(-100, 0, 0, 1'b0, 12868, 4);
        fix(0, -100, 0, 1'b0, -6434, 4);
        fix(0, 0, 0, 1'b0, 0, 0);
        fix(100, 100, 0, 1'b0, 3217, 4);
        fix(-128, -128, 0, 1'b0, -9651, 4);
        drv(1'b1, 127, -128, 0, 1'b0);
        idle(LAT);

        fix(100, 0, 1, 1'b1, 0, 0);
        fix(0, 100, 1, 1'b1, 6434, 8);
        drv(1'b1, -100, 1, 1, 1'b1);
        fix(-100, -1, 1, 1'b1, 82, 8);
        idle(LAT);

        for (int i = 0; i < 40; i++) drv(1'b1, rnd_s(), rnd_s(), (i % 2) * 2, 1'b1);
        idle(LAT);

        for (int i = 0; i < 10000; i++)
            drv($urandom_range(0, 9) < 7, rnd_s(), rnd_s(),
                int'($urandom_range(0, NUM_CH - 1)), 1'($urandom_range(0, 1)));
        idle(LAT);

        for (int i = 0; i < 5; i++) drv(1'b1, rnd_s(), rnd_s(), i % NUM_CH, 1'b0);
        step(1'b1, 1'b1, 50, 50, 1, 1'b0, 1'b0, 0, 0);
        idle(LAT + 2);
        fix(-50, 70, 3, 1'b1, 0, 0);
        fix(90, -20, 0, 1'b1, 0, 0);
        drv(1'b1, 30, 90, 3, 1'b1);
        idle(LAT + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
